ss_decoder_3bit: RTL and testbench

Windowed stochastic-symbol-to-binary decoder that sits directly downstream of the 3-bit stochastic divider. It consumes the divider's 3-bit symbol stream, sums exactly 2^LOG_WIN qualified symbols per window, and presents the sum as a binary result over a valid/ready handshake. It replaces a free-running accumulator with a bounded, restartable measurement window that a controller or testbench can sample deterministically.

---
 rtl/ss_decoder_3bit.sv | 130 +++++++++++++
 tb/tb_ss_decoder_3bit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_decoder_3bit.sv
// ss_decoder_3bit: windowed stochastic-symbol to binary decoder.
// Optional build macro SS_DECODER_AUTO_RESTART_EN selects continuous windows.
module ss_decoder_3bit #(
  parameter  int LOG_WIN = 7,
  localparam int ACC_W   = LOG_WIN + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ss_in,
  input  logic             in_valid,
  output logic [ACC_W-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [LOG_WIN-1:0] CNT_LAST = '1;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LOG_WIN-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   sum;
  logic               hs;

  assign sum = acc_q + ACC_W'(ss_in);
  assign hs  = out_valid_q & out_ready;

`ifdef SS_DECODER_AUTO_RESTART_EN
  logic overrun_q, overrun_d;
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  // Next-state, accumulation and result/handshake update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
`ifdef SS_DECODER_AUTO_RESTART_EN
    overrun_d   = overrun_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
`ifdef SS_DECODER_AUTO_RESTART_EN
        if (hs) out_valid_d = 1'b0;
`endif
        if (in_valid) begin
          if (cnt_q == CNT_LAST) begin
            result_d    = sum;
            out_valid_d = 1'b1;
`ifdef SS_DECODER_AUTO_RESTART_EN
            acc_d = '0;
            cnt_d = '0;
            if (out_valid_q && !out_ready)
              overrun_d = 1'b1;
`else
            state_d = HOLD;
`endif
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + LOG_WIN'(1);
          end
        end
      end
      HOLD: begin
        if (hs) begin
          out_valid_d = 1'b0;
          if (start) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SS_DECODER_AUTO_RESTART_EN
  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= overrun_d;
  end
`endif

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ss_decoder_3bit.sv
// tb_ss_decoder_3bit: directed bench for ss_decoder_3bit.
// Covers the default build, or the auto-restart build when its macro is set.
module tb_ss_decoder_3bit;

`ifdef SS_DECODER_AUTO_RESTART_EN
  localparam int LW = 3;
`else
  localparam int LW = 7;
`endif
  localparam int AW = LW + 3;
  localparam int W  = 1 << LW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    ss_in = 3'd0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  ss_decoder_3bit #(.LOG_WIN(LW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ss_in(ss_in),
    .in_valid(in_valid),
    .result(result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (result !== '0) begin
      errors++;
      $display("FAIL reset_result: got %0d want 0", result);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun: got %b want 0", overrun);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

`ifndef SS_DECODER_AUTO_RESTART_EN
  task automatic test_const7();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL c7_busy_after_start: got %b want 1", busy);
    end
    ss_in = 3'd7;
    in_valid = 1'b1;
    for (int i = 1; i <= W; i++) begin
      step();
      if (i < W) begin
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL c7_early i=%0d: got ov=%b busy=%b want 0 1",
                   i, out_valid, busy);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL c7_out_valid: got %b want 1", out_valid);
    end
    checks++;
    if (result !== AW'(7 * W)) begin
      errors++;
      $display("FAIL c7_result: got %0d want %0d", result, 7 * W);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL c7_handshake: got ov=%b busy=%b want 0 0",
               out_valid, busy);
    end
  endtask

  task automatic test_gapped_backpressure();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      in_valid = (i % 2 == 0);
      ss_in = in_valid ? 3'd5 : 3'd7;
      step();
      if (i == 2 * W - 3) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_early: got %b want 0", out_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== AW'(5 * W)) begin
      errors++;
      $display("FAIL gap_result: got ov=%b r=%0d want 1 %0d",
               out_valid, result, 5 * W);
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      ss_in = 3'd7;
      step();
      checks++;
      if (out_valid !== 1'b1 || result !== AW'(5 * W)) begin
        errors++;
        $display("FAIL bp_hold i=%0d: got ov=%b r=%0d want 1 %0d",
                 i, out_valid, result, 5 * W);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ov=%b busy=%b want 0 0",
               out_valid, busy);
    end
  endtask

  task automatic test_ignored_start();
    int exp;
    exp = 0;
    start = 1'b1;
    step();
    in_valid = 1'b1;
    for (int i = 0; i < W; i++) begin
      start = (i % 10 == 5);
      ss_in = 3'(i % 8);
      exp += i % 8;
      step();
    end
    start = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== AW'(exp)) begin
      errors++;
      $display("FAIL ign_result: got ov=%b r=%0d want 1 %0d",
               out_valid, result, exp);
    end
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got ov=%b busy=%b want 0 1",
               out_valid, busy);
    end
    ss_in = 3'd3;
    in_valid = 1'b1;
    for (int i = 0; i < W; i++) step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== AW'(3 * W)) begin
      errors++;
      $display("FAIL b2b_result: got ov=%b r=%0d want 1 %0d",
               out_valid, result, 3 * W);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    ss_in = 3'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) step();
    rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL rst_mid: got ov=%b busy=%b r=%0d want 0 0 0",
               out_valid, busy, result);
    end
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    ss_in = 3'd2;
    in_valid = 1'b1;
    for (int i = 0; i < W; i++) step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== AW'(2 * W)) begin
      errors++;
      $display("FAIL rst_fresh: got ov=%b r=%0d want 1 %0d",
               out_valid, result, 2 * W);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
`else
  task automatic test_auto_overrun();
    start = 1'b1;
    step();
    start = 1'b0;
    ss_in = 3'd1;
    in_valid = 1'b1;
    for (int i = 1; i <= 2 * W; i++) begin
      step();
      if (i == W) begin
        checks++;
        if (out_valid !== 1'b1 || result !== AW'(W) || overrun !== 1'b0) begin
          errors++;
          $display("FAIL ar_first: got ov=%b r=%0d orun=%b want 1 %0d 0",
                   out_valid, result, overrun, W);
        end
      end
    end
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ar_second: got orun=%b busy=%b want 1 1",
               overrun, busy);
    end
  endtask

  task automatic test_auto_ready();
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    ss_in = 3'd1;
    for (int i = 1; i <= W; i++) step();
    ss_in = 3'd2;
    for (int i = W + 1; i <= 2 * W; i++) begin
      out_ready = (i == 2 * W);
      step();
    end
    checks++;
    if (out_valid !== 1'b1 || result !== AW'(2 * W) || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ar_same_edge: got ov=%b r=%0d orun=%b want 1 %0d 0",
               out_valid, result, overrun, 2 * W);
    end
    out_ready = 1'b1;
    ss_in = 3'd1;
    for (int i = 2 * W + 1; i <= 4 * W; i++) begin
      step();
      if (i % W == 1) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL ar_drop i=%0d: got %b want 0", i, out_valid);
        end
      end
      if (i % W == 0) begin
        checks++;
        if (out_valid !== 1'b1 || result !== AW'(W) || overrun !== 1'b0) begin
          errors++;
          $display("FAIL ar_ready i=%0d: got ov=%b r=%0d orun=%b want 1 %0d 0",
                   i, out_valid, result, overrun, W);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifndef SS_DECODER_AUTO_RESTART_EN
    test_const7();
    test_gapped_backpressure();
    test_ignored_start();
    test_reset_mid();
`else
    test_auto_overrun();
    test_auto_ready();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
